// File: rtl/lcd_ctrl_param_if.sv
// rtl/lcd_ctrl_param_if.sv - ROM, command and result-buffer signal bundle for lcd_ctrl_param
interface lcd_ctrl_param_if #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
);
  localparam int AW = $clog2(IMG_W * IMG_H);

  logic [DW-1:0] IROM_Q;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          IROM_EN;
  logic [AW-1:0] IROM_A;
  logic          IRB_RW;
  logic [DW-1:0] IRB_D;
  logic [AW-1:0] IRB_A;
  logic          busy;
  logic          done;

  modport master (
    input  IROM_Q, cmd, cmd_valid,
    output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );

  modport slave (
    output IROM_Q, cmd, cmd_valid,
    input  IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// rtl/lcd_ctrl_param.sv - parametrised LCD image controller with 2x2 window ops
// Optional max/min commands (8/9) are built only when LCD_CTRL_MINMAX_EN is defined.
module lcd_ctrl_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  lcd_ctrl_param_if.master  bus
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_MID  = XW'(IMG_W / 2);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_MID  = YW'(IMG_H / 2);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [2:0] {
    S_RST, S_LOAD, S_LOAD_TAIL, S_IDLE, S_EXEC, S_WRITE, S_DONE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_buf [N];
  logic [3:0]    r_cmd;
  logic [XW-1:0] r_px;
  logic [YW-1:0] r_py;

  logic          r_irom_en;
  logic [AW-1:0] r_irom_a;
  logic          r_irb_rw;
  logic [DW-1:0] r_irb_d;
  logic [AW-1:0] r_irb_a;
  logic          r_busy;
  logic          r_done;

  assign bus.IROM_EN = r_irom_en;
  assign bus.IROM_A  = r_irom_a;
  assign bus.IRB_RW  = r_irb_rw;
  assign bus.IRB_D   = r_irb_d;
  assign bus.IRB_A   = r_irb_a;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  // Power-of-two dimensions make y*IMG_W + x a plain concatenation.
  logic [XW-1:0] w_xl;
  logic [YW-1:0] w_yt;
  logic [AW-1:0] w_addr_a, w_addr_b, w_addr_c, w_addr_d;
  logic [DW-1:0] w_pa, w_pb, w_pc, w_pd;

  assign w_xl     = r_px - X_ONE;
  assign w_yt     = r_py - Y_ONE;
  assign w_addr_a = {w_yt, w_xl};
  assign w_addr_b = {w_yt, r_px};
  assign w_addr_c = {r_py, w_xl};
  assign w_addr_d = {r_py, r_px};
  assign w_pa     = r_buf[w_addr_a];
  assign w_pb     = r_buf[w_addr_b];
  assign w_pc     = r_buf[w_addr_c];
  assign w_pd     = r_buf[w_addr_d];

  logic [DW+1:0] w_sum;
  logic [DW-1:0] w_avg;

  assign w_sum = {2'b00, w_pa} + {2'b00, w_pb} + {2'b00, w_pc} + {2'b00, w_pd};
  assign w_avg = DW'(w_sum >> 2);

`ifdef LCD_CTRL_MINMAX_EN
  logic [DW-1:0] w_max_ab, w_max_cd, w_max;
  logic [DW-1:0] w_min_ab, w_min_cd, w_min;

  assign w_max_ab = (w_pa > w_pb) ? w_pa : w_pb;
  assign w_max_cd = (w_pc > w_pd) ? w_pc : w_pd;
  assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;
  assign w_min_ab = (w_pa < w_pb) ? w_pa : w_pb;
  assign w_min_cd = (w_pc < w_pd) ? w_pc : w_pd;
  assign w_min    = (w_min_ab < w_min_cd) ? w_min_ab : w_min_cd;
`endif

  logic [DW-1:0] w_na, w_nb, w_nc, w_nd;
  logic          w_win_we;

  always_comb begin
    w_na     = w_pa;
    w_nb     = w_pb;
    w_nc     = w_pc;
    w_nd     = w_pd;
    w_win_we = 1'b0;
    if (r_state == S_EXEC) begin
      case (r_cmd)
        4'd5: begin
          w_na = w_avg; w_nb = w_avg; w_nc = w_avg; w_nd = w_avg;
          w_win_we = 1'b1;
        end
        4'd6: begin
          w_na = w_pc; w_nb = w_pd; w_nc = w_pa; w_nd = w_pb;
          w_win_we = 1'b1;
        end
        4'd7: begin
          w_na = w_pb; w_nb = w_pa; w_nc = w_pd; w_nd = w_pc;
          w_win_we = 1'b1;
        end
`ifdef LCD_CTRL_MINMAX_EN
        4'd8: begin
          w_na = w_max; w_nb = w_max; w_nc = w_max; w_nd = w_max;
          w_win_we = 1'b1;
        end
        4'd9: begin
          w_na = w_min; w_nb = w_min; w_nc = w_min; w_nd = w_min;
          w_win_we = 1'b1;
        end
`endif
        4'd10: begin
          w_na = w_pc; w_nb = w_pa; w_nd = w_pb; w_nc = w_pd;
          w_win_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame storage is deliberately not reset; it is rewritten by every load.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && r_irom_a != '0) begin
      r_buf[r_irom_a - A_ONE] <= bus.IROM_Q;
    end else if (r_state == S_LOAD_TAIL) begin
      r_buf[A_LAST] <= bus.IROM_Q;
    end else if (w_win_we) begin
      r_buf[w_addr_a] <= w_na;
      r_buf[w_addr_b] <= w_nb;
      r_buf[w_addr_c] <= w_nc;
      r_buf[w_addr_d] <= w_nd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_RST;
      r_cmd     <= 4'd0;
      r_px      <= X_MID;
      r_py      <= Y_MID;
      r_irom_en <= 1'b1;
      r_irom_a  <= '0;
      r_irb_rw  <= 1'b1;
      r_irb_d   <= '0;
      r_irb_a   <= '0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state   <= S_LOAD;
          r_irom_en <= 1'b0;
          r_irom_a  <= '0;
        end
        S_LOAD: begin
          if (r_irom_a == A_LAST) begin
            r_state   <= S_LOAD_TAIL;
            r_irom_en <= 1'b1;
          end else begin
            r_irom_a <= r_irom_a + A_ONE;
          end
        end
        S_LOAD_TAIL: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_cmd  <= bus.cmd;
            r_busy <= 1'b1;
            if (bus.cmd == 4'd0) begin
              r_state  <= S_WRITE;
              r_irb_rw <= 1'b0;
              r_irb_a  <= '0;
              r_irb_d  <= r_buf[0];
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          case (r_cmd)
            4'd1: if (r_py != Y_ONE) r_py <= r_py - Y_ONE;
            4'd2: if (r_py != Y_MAX) r_py <= r_py + Y_ONE;
            4'd3: if (r_px != X_ONE) r_px <= r_px - X_ONE;
            4'd4: if (r_px != X_MAX) r_px <= r_px + X_ONE;
            4'd11: begin
              r_px <= X_MID;
              r_py <= Y_MID;
            end
            default: ;
          endcase
        end
        S_WRITE: begin
          if (r_irb_a == A_LAST) begin
            r_state  <= S_DONE;
            r_irb_rw <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_irb_a <= r_irb_a + A_ONE;
            r_irb_d <= r_buf[r_irb_a + A_ONE];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb/tb_lcd_ctrl_param.sv - directed-vector bench for lcd_ctrl_param (8x8 and 16x4 instances)
module tb_lcd_ctrl_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic reset_n2;

  lcd_ctrl_param_if #(.IMG_W(8), .IMG_H(8), .DW(8)) bus ();
  lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .DW(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  lcd_ctrl_param_if #(.IMG_W(16), .IMG_H(4), .DW(8)) bus2 ();
  lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DW(8)) dut2 (
    .clk(clk), .reset_n(reset_n2), .bus(bus2)
  );

  logic [7:0] rom  [64];
  logic [7:0] rom2 [64];
  logic [7:0] img  [64];
  logic [7:0] img2 [64];

  // Synchronous ROMs: data appears the cycle after the address.
  always @(posedge clk) if (!bus.IROM_EN)  bus.IROM_Q  <= rom[bus.IROM_A];
  always @(posedge clk) if (!bus2.IROM_EN) bus2.IROM_Q <= rom2[bus2.IROM_A];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_rst(input string t);
    check({t, "_irom_en"}, bus.IROM_EN, 1);
    check({t, "_irom_a"},  bus.IROM_A, 0);
    check({t, "_irb_rw"},  bus.IRB_RW, 1);
    check({t, "_irb_a"},   bus.IRB_A, 0);
    check({t, "_irb_d"},   bus.IRB_D, 0);
    check({t, "_busy"},    bus.busy, 1);
    check({t, "_done"},    bus.done, 0);
  endtask

  // Counts cycles from release to busy low; pulses cmd=1 once during LOAD.
  task automatic wait_load(input string tag);
    int cnt = 0;
    while (bus.busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (cnt == 10) begin
        bus.cmd = 4'd1; bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    check(tag, cnt, 66);
  endtask

  task automatic send(input logic [3:0] c);
    bus.cmd = c; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("cmd_busy_hi", bus.busy, 1);
    @(negedge clk);
    check("cmd_busy_lo", bus.busy, 0);
  endtask

  task automatic write_frame(input int pulse_k);
    int nbad = 0;
    bus.cmd = 4'd0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check("wr_addr", bus.IRB_A, k);
      if (bus.IRB_RW !== 1'b0) nbad++;
      img[k] = bus.IRB_D;
      if (k == pulse_k) begin
        bus.cmd = 4'd1; bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd = 4'd0;
    check("wr_rw_low", nbad, 0);
    check("done_hi", bus.done, 1);
    check("done_busy", bus.busy, 1);
    check("done_rw", bus.IRB_RW, 1);
    @(negedge clk);
    check("done_lo", bus.done, 0);
    check("after_busy_lo", bus.busy, 0);
  endtask

  task automatic send2(input logic [3:0] c);
    bus2.cmd = c; bus2.cmd_valid = 1'b1;
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
    check("c2_busy_hi", bus2.busy, 1);
    @(negedge clk);
    check("c2_busy_lo", bus2.busy, 0);
  endtask

  task automatic write2();
    bus2.cmd = 4'd0; bus2.cmd_valid = 1'b1;
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      img2[k] = bus2.IRB_D;
      @(negedge clk);
    end
    check("w2_done", bus2.done, 1);
    @(negedge clk);
    check("w2_busy_lo", bus2.busy, 0);
  endtask

  initial begin
    int cnt;
    int e_a, e_b, e_c, e_d;
    reset_n = 1'b0; reset_n2 = 1'b0;
    bus.cmd = 4'd0;  bus.cmd_valid = 1'b0;
    bus2.cmd = 4'd0; bus2.cmd_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      rom[k]  = 8'(k);
      rom2[k] = 8'(k);
    end
    rom2[23] = 8'd3; rom2[24] = 8'd250; rom2[39] = 8'd7; rom2[40] = 8'd9;

    repeat (2) @(negedge clk);
    chk_rst("rst");
    reset_n = 1'b1;
    wait_load("load_cycles");

    // Plain frame out, with an ignored command mid-write.
    write_frame(30);
    for (int k = 0; k < 64; k++) check("wr_data", img[k], k);

    // Average at (4,4): 27,28,35,36 -> 31; window must not have moved.
    send(4'd5);
    write_frame(-1);
    check("avg44_a", img[27], 31); check("avg44_b", img[28], 31);
    check("avg44_c", img[35], 31); check("avg44_d", img[36], 31);
    check("avg44_19", img[19], 19); check("avg44_20", img[20], 20);

    // Saturation to (1,1) then average of 0,1,8,9 -> 4.
    repeat (5) send(4'd1);
    repeat (5) send(4'd3);
    send(4'd5);
    write_frame(-1);
    check("sat_0", img[0], 4); check("sat_1", img[1], 4);
    check("sat_8", img[8], 4); check("sat_9", img[9], 4);
    check("sat_2", img[2], 2); check("keep_27", img[27], 31);

    // Reset while IRB_A=20, then reload a new ROM image.
    bus.cmd = 4'd0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_irb_a", bus.IRB_A, 20);
    reset_n = 1'b0;
    #1;
    chk_rst("midrst");
    for (int k = 0; k < 64; k++) rom[k] = 8'(100 + k);
    rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd40;
    @(negedge clk);
    reset_n = 1'b1;
    wait_load("reload_cycles");
    write_frame(-1);
    for (int k = 0; k < 64; k++) check("reload_data", img[k], rom[k]);

    send(4'd6);
    write_frame(-1);
    check("mx_a", img[27], 30); check("mx_b", img[28], 40);
    check("mx_c", img[35], 10); check("mx_d", img[36], 20);
    send(4'd7);
    write_frame(-1);
    check("my_a", img[27], 40); check("my_b", img[28], 30);
    check("my_c", img[35], 20); check("my_d", img[36], 10);
    send(4'd10);
    write_frame(-1);
    check("rot_a", img[27], 20); check("rot_b", img[28], 40);
    check("rot_c", img[35], 10); check("rot_d", img[36], 30);
    check("rot_26", img[26], 126);

    // 16x4 instance: window at (8,2) covers 23,24,39,40.
    @(negedge clk);
    reset_n2 = 1'b1;
    cnt = 0;
    while (bus2.busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("load2_cycles", cnt, 66);
    send2(4'd8);
    write2();
`ifdef LCD_CTRL_MINMAX_EN
    e_a = 250; e_b = 250; e_c = 250; e_d = 250;
`else
    e_a = 3; e_b = 250; e_c = 7; e_d = 9;
`endif
    check("mm_a", img2[23], e_a); check("mm_b", img2[24], e_b);
    check("mm_c", img2[39], e_c); check("mm_d", img2[40], e_d);
    check("mm_25", img2[25], 25);

    // Move away, recentre, average: (3+250+7+9)/4 = 67 when unchanged by max.
    send2(4'd4); send2(4'd4); send2(4'd1); send2(4'd11); send2(4'd5);
    write2();
`ifdef LCD_CTRL_MINMAX_EN
    e_a = 250;
`else
    e_a = 67;
`endif
    check("rc_a", img2[23], e_a); check("rc_b", img2[24], e_a);
    check("rc_c", img2[39], e_a); check("rc_d", img2[40], e_a);
    check("rc_25", img2[25], 25); check("rc_10", img2[10], 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
